// File: rtl/data_write_buffer.sv
// Posted-write FIFO between the dcache uncached/miss port and the AXI bridge.
// Writes are acked the cycle after acceptance; reads bypass only once all posted writes have completed.
module data_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        up_req,
    input  logic        up_wr,
    input  logic [1:0]  up_size,
    input  logic [31:0] up_addr,
    input  logic [31:0] up_wdata,
    input  logic [3:0]  up_wstrb,
    output logic [31:0] up_rdata,
    output logic        up_addr_ok,
    output logic        up_data_ok,
    output logic        dn_req,
    output logic        dn_wr,
    output logic [1:0]  dn_size,
    output logic [31:0] dn_addr,
    output logic [31:0] dn_wdata,
    output logic [3:0]  dn_wstrb,
    input  logic [31:0] dn_rdata,
    input  logic        dn_addr_ok,
    input  logic        dn_data_ok
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } entry_t;

    entry_t        r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_dn_busy;
    logic          r_dn_is_rd;
    logic          r_rd_busy;
    logic          r_wr_ack;

    logic   w_full;
    logic   w_empty;
    logic   w_wr_accept;
    logic   w_rd_elig;
    logic   w_rd_issue;
    logic   w_drain;
    logic   w_pop;
    logic   w_complete;
    entry_t w_up_entry;
    entry_t w_head;
    entry_t w_dn_entry;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    assign w_up_entry = '{size: up_size, addr: up_addr, wdata: up_wdata, wstrb: up_wstrb};
    // Head is read asynchronously so an entry pushed at t can be offered to the bridge at t+1.
    assign w_head     = r_mem[r_rd_ptr];

    // A full FIFO refuses writes even when a pop lands in the same cycle.
    assign w_wr_accept = !rst && up_req && up_wr && !w_full && !r_rd_busy;
    assign w_rd_elig   = !rst && up_req && !up_wr && w_empty && !r_dn_busy && !r_rd_busy;
    assign w_rd_issue  = w_rd_elig && dn_addr_ok;
    assign w_drain     = !rst && !w_empty && !r_dn_busy;
    assign w_pop       = w_drain && dn_addr_ok;
    assign w_complete  = r_dn_busy && dn_data_ok;

    // Read eligibility needs an empty FIFO, so drain and read requests never overlap.
    assign w_dn_entry = w_empty ? w_up_entry : w_head;

    assign dn_req   = w_drain || w_rd_elig;
    assign dn_wr    = w_drain;
    assign dn_size  = w_dn_entry.size;
    assign dn_addr  = w_dn_entry.addr;
    assign dn_wdata = w_dn_entry.wdata;
    assign dn_wstrb = w_dn_entry.wstrb;

    assign up_addr_ok = w_wr_accept || w_rd_issue;
    assign up_data_ok = !rst && (r_wr_ack || (w_complete && r_dn_is_rd));
    assign up_rdata   = dn_rdata;

    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= w_up_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_dn_busy  <= 1'b0;
            r_dn_is_rd <= 1'b0;
            r_rd_busy  <= 1'b0;
            r_wr_ack   <= 1'b0;
        end else begin
            r_wr_ack <= w_wr_accept;

            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            case ({w_wr_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // Issue needs !r_dn_busy and completion needs r_dn_busy, so they are exclusive.
            if (w_pop || w_rd_issue) begin
                r_dn_busy  <= 1'b1;
                r_dn_is_rd <= w_rd_issue;
            end else if (w_complete) begin
                r_dn_busy  <= 1'b0;
            end

            // rd_busy drops only after the data_ok cycle, keeping writes blocked through it.
            if (w_rd_issue) begin
                r_rd_busy <= 1'b1;
            end else if (w_complete && r_dn_is_rd) begin
                r_rd_busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_data_write_buffer.sv
// Scoreboard bench for data_write_buffer with a behavioural one-outstanding bridge model.
module tb_data_write_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        up_req, up_wr;
    logic [1:0]  up_size;
    logic [31:0] up_addr, up_wdata;
    logic [3:0]  up_wstrb;
    logic [31:0] up_rdata;
    logic        up_addr_ok, up_data_ok;
    logic        dn_req, dn_wr;
    logic [1:0]  dn_size;
    logic [31:0] dn_addr, dn_wdata;
    logic [3:0]  dn_wstrb;
    logic [31:0] dn_rdata;
    logic        dn_addr_ok, dn_data_ok;

    data_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .up_req(up_req), .up_wr(up_wr), .up_size(up_size), .up_addr(up_addr),
        .up_wdata(up_wdata), .up_wstrb(up_wstrb), .up_rdata(up_rdata),
        .up_addr_ok(up_addr_ok), .up_data_ok(up_data_ok),
        .dn_req(dn_req), .dn_wr(dn_wr), .dn_size(dn_size), .dn_addr(dn_addr),
        .dn_wdata(dn_wdata), .dn_wstrb(dn_wstrb), .dn_rdata(dn_rdata),
        .dn_addr_ok(dn_addr_ok), .dn_data_ok(dn_data_ok)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;

    typedef logic [70:0] txn_t;
    txn_t        exp_dn_q[$];
    logic [31:0] exp_rd_q[$];

    // bridge model knobs and state
    bit          br_busy = 0, br_is_rd = 0, br_stall = 0, br_rand = 0;
    int          br_cnt = 0, br_wait = 0, br_addr_wait = 0, br_lat = 2;
    logic [31:0] br_rdata = '0;

    int n_dn_wr = 0, wr_dok_cnt = 0, last_wr_dok_cyc = -1, last_rd_dok_cyc = -1;
    bit prev_wr_acc = 0;
    bit mon_rd_done, mon_exp_dok;
    txn_t mon_got;

    task automatic check_val(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        n_compared++;
        if (obs !== expv) begin
            n_mismatched++;
            $display("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // bridge drive: after the upstream driver has settled each cycle
    initial begin
        dn_addr_ok = 1'b0;
        dn_data_ok = 1'b0;
        dn_rdata   = '0;
        forever begin
            @(posedge clk);
            #2;
            dn_data_ok = !rst && br_busy && (br_cnt == 1);
            dn_rdata   = (dn_data_ok && br_is_rd) ? br_rdata : 32'h0;
            dn_addr_ok = !rst && !br_busy && dn_req && !br_stall && (br_wait >= br_addr_wait);
        end
    end

    // monitor: scoreboard push on accept, pop on bridge handshake / read completion
    initial forever begin
        @(negedge clk);
        if (rst) begin
            exp_dn_q.delete();
            exp_rd_q.delete();
            prev_wr_acc = 0;
            br_busy     = 0;
            br_wait     = 0;
        end else begin
            mon_rd_done = dn_data_ok && br_busy && br_is_rd;
            mon_exp_dok = prev_wr_acc || mon_rd_done;
            if (up_data_ok || mon_exp_dok)
                check_val("up_data_ok", up_data_ok, mon_exp_dok);
            if (mon_rd_done) begin
                check_val("rd_expected", exp_rd_q.size() != 0, 1);
                if (exp_rd_q.size() != 0)
                    check_val("up_rdata", up_rdata, exp_rd_q.pop_front());
            end
            if (br_busy)
                check_val("one_outstanding", dn_req, 0);

            prev_wr_acc = up_req && up_wr && up_addr_ok;
            if (up_req && up_addr_ok) begin
                exp_dn_q.push_back({up_wr, up_size, up_addr, up_wdata, up_wstrb});
                if (!up_wr) exp_rd_q.push_back(br_rdata);
            end

            if (br_busy) begin
                if (dn_data_ok) begin
                    br_busy = 0;
                    if (br_is_rd) last_rd_dok_cyc = cyc;
                    else begin
                        wr_dok_cnt++;
                        last_wr_dok_cyc = cyc;
                    end
                end else begin
                    br_cnt--;
                end
            end

            if (dn_req && dn_addr_ok) begin
                mon_got = {dn_wr, dn_size, dn_addr, dn_wdata, dn_wstrb};
                $display("[%0d] bridge %s addr=%08h wdata=%08h wstrb=%h",
                         cyc, dn_wr ? "WR" : "RD", dn_addr, dn_wdata, dn_wstrb);
                check_val("dn_txn_expected", exp_dn_q.size() != 0, 1);
                if (exp_dn_q.size() != 0)
                    check_val("dn_txn", mon_got, exp_dn_q.pop_front());
                br_busy  = 1;
                br_is_rd = !dn_wr;
                br_cnt   = br_lat;
                br_wait  = 0;
                if (dn_wr) n_dn_wr++;
                if (br_rand) begin
                    br_addr_wait = $urandom_range(0, 3);
                    br_lat       = $urandom_range(1, 4);
                end
            end else if (dn_req) begin
                br_wait++;
            end
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output int acc_cyc);
        up_req = 1; up_wr = 1; up_size = 2'd2; up_addr = a; up_wdata = d; up_wstrb = s;
        acc_cyc = -1;
        for (int i = 0; i < 200; i++) begin
            sample();
            if (up_addr_ok) begin
                acc_cyc = cyc;
                break;
            end
            tick();
        end
        check_val("wr_accept", up_addr_ok, 1);
        tick();
        up_req = 0;
    endtask

    task automatic rd_issue(input logic [31:0] a, output int acc_cyc);
        up_req = 1; up_wr = 0; up_size = 2'd2; up_addr = a; up_wdata = '0; up_wstrb = '0;
        acc_cyc = -1;
        for (int i = 0; i < 200; i++) begin
            sample();
            if (up_addr_ok) begin
                acc_cyc = cyc;
                break;
            end
            tick();
        end
        check_val("rd_accept", up_addr_ok, 1);
        tick();
        up_req = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            sample();
            if (!br_busy && !dn_req && exp_dn_q.size() == 0) break;
            tick();
        end
        check_val("drain_idle", {br_busy, dn_req, exp_dn_q.size() != 0}, 3'b000);
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc[6];
        int racc, wacc, base;
        bit got;
        rst = 1; up_req = 0; up_wr = 0; up_size = '0; up_addr = '0; up_wdata = '0; up_wstrb = '0;

        // reset state
        repeat (3) tick();
        sample();
        check_val("rst_up_addr_ok", up_addr_ok, 0);
        check_val("rst_up_data_ok", up_data_ok, 0);
        check_val("rst_dn_req", dn_req, 0);
        tick();
        rst = 0;
        sample();
        check_val("post_rst_dn_req", dn_req, 0);
        check_val("post_rst_dn_wr", dn_wr, 0);
        check_val("post_rst_up_data_ok", up_data_ok, 0);
        tick();

        // single write, bridge addr_ok at once, data_ok two cycles later
        br_lat = 2;
        up_req = 1; up_wr = 1; up_size = 2'd2; up_addr = 32'h1000; up_wdata = 32'hDEADBEEF; up_wstrb = 4'hF;
        sample();
        check_val("t1_addr_ok", up_addr_ok, 1);
        check_val("t1_no_dn_req_yet", dn_req, 0);
        tick();
        up_req = 0;
        sample();
        check_val("t1_ack", up_data_ok, 1);
        check_val("t1_dn_req", dn_req, 1);
        check_val("t1_dn_fields", {dn_wr, dn_size, dn_addr, dn_wdata, dn_wstrb},
                  {1'b1, 2'd2, 32'h1000, 32'hDEADBEEF, 4'hF});
        tick();
        sample();
        check_val("t1_busy_no_req", dn_req, 0);
        tick();
        sample();
        check_val("t1_dn_data_ok", dn_data_ok, 1);
        check_val("t1_wr_cpl_not_fwd", up_data_ok, 0);
        tick();
        sample();
        check_val("t1_empty_after_pop", dn_req, 0);
        tick();

        // five back-to-back writes against a stalled bridge
        br_stall = 1; br_lat = 1;
        for (int i = 0; i < 4; i++) wr(32'h100 + 32'(4 * i), $urandom, 4'hF, acc[i]);
        for (int i = 1; i < 4; i++) check_val("t2_b2b_accept", acc[i] - acc[i-1], 1);
        up_req = 1; up_wr = 1; up_addr = 32'h110; up_wdata = 32'h55AA55AA; up_wstrb = 4'hC;
        for (int i = 0; i < 3; i++) begin
            sample();
            check_val("t2_full_hold", up_addr_ok, 0);
            tick();
        end
        br_stall = 0;
        sample();
        check_val("t2_pop_now", dn_req && dn_addr_ok, 1);
        check_val("t2_full_refused_on_pop", up_addr_ok, 0);
        tick();
        sample();
        check_val("t2_fifth_accept", up_addr_ok, 1);
        tick();
        up_req = 0;
        wait_idle();

        // wrap-around with random bridge timing
        br_rand = 1;
        base = n_dn_wr;
        for (int i = 0; i < 6; i++) wr(32'h10 + 32'(4 * i), $urandom, 4'(i + 1), acc[i]);
        wait_idle();
        check_val("t3_wr_count", n_dn_wr - base, 6);
        br_rand = 0; br_addr_wait = 0;

        // read after two posted writes
        br_lat = 3; br_rdata = 32'h12345678;
        base = wr_dok_cnt;
        wr(32'h200, 32'hA5A5A5A5, 4'hF, acc[0]);
        wr(32'h204, 32'h5A5A5A5A, 4'h3, acc[1]);
        rd_issue(32'h2000, racc);
        check_val("t4_writes_done_first", wr_dok_cnt - base, 2);
        check_val("t4_read_issue_cycle", racc, last_wr_dok_cyc + 1);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            sample();
            if (up_data_ok) begin
                got = 1;
                check_val("t4_rdata", up_rdata, 32'h12345678);
                check_val("t4_rd_latency", cyc - racc, 3);
                tick();
                break;
            end
            tick();
        end
        check_val("t4_rd_done", got, 1);
        wait_idle();

        // write presented while a read is outstanding
        br_lat = 3; br_rdata = 32'hCAFEF00D;
        rd_issue(32'h3000, racc);
        wr(32'h40, 32'h0BADCAFE, 4'hF, wacc);
        check_val("t5_wr_after_rd_dok", wacc, last_rd_dok_cyc + 1);
        check_val("t5_wr_accept_cycle", wacc - racc, 4);
        wait_idle();

        // reset with three entries queued and one write outstanding
        br_lat = 10;
        for (int i = 0; i < 4; i++) wr(32'h300 + 32'(4 * i), $urandom, 4'hF, acc[i]);
        rst = 1;
        tick();
        rst = 0;
        sample();
        check_val("t6_dn_req", dn_req, 0);
        check_val("t6_up_data_ok", up_data_ok, 0);
        check_val("t6_up_addr_ok", up_addr_ok, 0);
        tick();
        br_lat = 2;
        base = n_dn_wr;
        wr(32'h5000, 32'h600DF00D, 4'hF, wacc);
        wait_idle();
        check_val("t6_single_txn", n_dn_wr - base, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
